// File: rtl/zest_spi_arb_pkg.sv
// rtl/zest_spi_arb_pkg.sv - shared types and constants for the Zest P2 SPI arbiter
package zest_spi_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_GAP
   } arb_state_t;

   localparam int DEF_N_REQ = 4;

   // Requester slots on the P2 SPI pins
   localparam int REQ_U1 = 0;   // LMK01801 uWire
   localparam int REQ_U2 = 1;   // AD9653 U2
   localparam int REQ_U3 = 2;   // AD9653 U3
   localparam int REQ_U4 = 3;   // AD9781 U4

   // Index width that stays at least one bit for single-entry vectors
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zest_spi_arb_if.sv
// rtl/zest_spi_arb_if.sv - requester/pin bundle between chip drivers and the arbiter
interface zest_spi_arb_if
   import zest_spi_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
);
   localparam int IW = idx_w(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] m_sclk;
   logic [N_REQ-1:0] m_mosi;
   logic [N_REQ-1:0] m_csb;
   logic [N_REQ-1:0] m_sdio_as_i;
   logic             spi_sclk;
   logic             spi_mosi;
   logic [N_REQ-1:0] spi_csb;
   logic             spi_sdio_as_i;
   logic             timeout_stb;
   logic [IW-1:0]    timeout_id;
   logic             busy;

   modport slave (
      input  req, m_sclk, m_mosi, m_csb, m_sdio_as_i,
      output grant, spi_sclk, spi_mosi, spi_csb, spi_sdio_as_i,
             timeout_stb, timeout_id, busy
   );

   modport master (
      output req, m_sclk, m_mosi, m_csb, m_sdio_as_i,
      input  grant, spi_sclk, spi_mosi, spi_csb, spi_sdio_as_i,
             timeout_stb, timeout_id, busy
   );

endinterface

// File: rtl/zest_spi_arb_rr_pick.sv
// rtl/zest_spi_arb_rr_pick.sv - combinational round-robin priority encoder
module zest_spi_arb_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    win,
   output logic             valid
);
   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Scan from ptr upwards with wrap; first requester found wins
   always_comb begin
      win   = '0;
      valid = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N_REQ)) begin
            sum = sum - (IW + 1)'(N_REQ);
         end
         idx = sum[IW-1:0];
         if (!valid && req[idx]) begin
            win   = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/zest_spi_arb.sv
// rtl/zest_spi_arb.sv - round-robin owner of the Zest P2 SPI pins with guard gap and watchdog
module zest_spi_arb
   import zest_spi_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int GAP     = 4,
   parameter int TIMEOUT = 4096
) (
   input logic            clk,
   input logic            rst_n,
   zest_spi_arb_if.slave  bus
);
   localparam int IW = idx_w(N_REQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = idx_w(GAP);
   localparam logic [IW-1:0] LAST     = IW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_LIM  = CW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   arb_state_t       state_q, state_n;
   logic [IW-1:0]    owner_q, owner_n;
   logic [IW-1:0]    ptr_q, ptr_n;
   logic [CW-1:0]    cnt_q, cnt_n, cnt_inc;
   logic [GW-1:0]    gcnt_q, gcnt_n;
   logic [N_REQ-1:0] stale_q, stale_n, stale_set;
   logic [N_REQ-1:0] grant_q, grant_n;
   logic [N_REQ-1:0] csb_q, csb_n;
   logic             sclk_q, sclk_n;
   logic             mosi_q, mosi_n;
   logic             dir_q, dir_n;
   logic             stb_q, stb_n;
   logic [IW-1:0]    id_q, id_n;
   logic             busy_q, busy_n;

   logic [N_REQ-1:0] eligible;
   logic [IW-1:0]    pick_win;
   logic             pick_valid;

   // A master that was reclaimed stays out until it drops req
   assign eligible = bus.req & ~stale_q;

   zest_spi_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req   (eligible),
      .ptr   (ptr_q),
      .win   (pick_win),
      .valid (pick_valid)
   );

   // Next-state, watchdog/gap counters and the registered pin mux
   always_comb begin
      state_n   = state_q;
      owner_n   = owner_q;
      ptr_n     = ptr_q;
      cnt_n     = cnt_q;
      gcnt_n    = gcnt_q;
      grant_n   = grant_q;
      stb_n     = 1'b0;
      id_n      = id_q;
      stale_set = '0;
      cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_n = ARB_GRANT;
               grant_n = '0;
               grant_n[pick_win] = 1'b1;
               owner_n = pick_win;
               ptr_n   = (pick_win == LAST) ? '0 : pick_win + IW'(1);
               cnt_n   = '0;
            end
         end
         ARB_GRANT: begin
            // A release in the same cycle as the limit wins over the watchdog
            if (!bus.req[owner_q]) begin
               state_n = ARB_GAP;
               grant_n = '0;
               gcnt_n  = '0;
            end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIM)) begin
               state_n = ARB_GAP;
               grant_n = '0;
               gcnt_n  = '0;
               stb_n   = 1'b1;
               id_n    = owner_q;
               stale_set[owner_q] = 1'b1;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         ARB_GAP: begin
            if (gcnt_q == GAP_LAST) begin
               state_n = ARB_IDLE;
            end else begin
               gcnt_n = gcnt_q + GW'(1);
            end
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
         end
      endcase

      stale_n = (stale_q & bus.req) | stale_set;
      busy_n  = (state_n != ARB_IDLE);

      sclk_n = 1'b0;
      mosi_n = 1'b0;
      dir_n  = 1'b0;
      csb_n  = '1;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_n[i]) begin
            sclk_n   = bus.m_sclk[i];
            mosi_n   = bus.m_mosi[i];
            dir_n    = bus.m_sdio_as_i[i];
            csb_n[i] = bus.m_csb[i];
         end
      end
   end

   // State and output registers; reset drops the pins to idle without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         stale_q <= '0;
         grant_q <= '0;
         csb_q   <= '1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         dir_q   <= 1'b0;
         stb_q   <= 1'b0;
         id_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
         gcnt_q  <= gcnt_n;
         stale_q <= stale_n;
         grant_q <= grant_n;
         csb_q   <= csb_n;
         sclk_q  <= sclk_n;
         mosi_q  <= mosi_n;
         dir_q   <= dir_n;
         stb_q   <= stb_n;
         id_q    <= id_n;
         busy_q  <= busy_n;
      end
   end

   assign bus.grant         = grant_q;
   assign bus.spi_sclk      = sclk_q;
   assign bus.spi_mosi      = mosi_q;
   assign bus.spi_csb       = csb_q;
   assign bus.spi_sdio_as_i = dir_q;
   assign bus.timeout_stb   = stb_q;
   assign bus.timeout_id    = id_q;
   assign bus.busy          = busy_q;

endmodule
